// File: rtl/bus_pkg.sv
// Shared definitions for the request/finish bus initiator: widths, FSM encoding
// and the default watchdog limit.
package bus_pkg;

   localparam int ADDR_W          = 16;
   localparam int DATA_W          = 8;
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/bus_master_if.sv
// Client request/response handshake plus responder-side bus signals.
// master = initiator view, slave = client and responder view.
interface bus_master_if;
   import bus_pkg::*;

   // Client handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; rsp_valid is a one-cycle pulse with no back-pressure.
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              Cmd;
   logic              RW;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] WData;
   logic [DATA_W-1:0] RData;
   logic              Finish;

   modport master (
      input  req_valid, req_rw, req_addr, req_wdata, RData, Finish,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, Cmd, RW, Addr, WData
   );

   modport slave (
      output req_valid, req_rw, req_addr, req_wdata, RData, Finish,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, Cmd, RW, Addr, WData
   );

endinterface

// File: rtl/bus_watchdog.sv
// Cycle counter for the optional transaction watchdog (BUS_MASTER_TIMEOUT_EN).
// o_expired fires in the cycle whose increment would reach LIMIT.
module bus_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expired
);

   logic [15:0] r_count;
   logic [15:0] w_count_inc;

   assign w_count_inc = r_count + 16'd1;
   assign o_expired   = i_en && (w_count_inc == LIMIT[15:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_count_inc;
      end
   end

endmodule

// File: rtl/bus_master.sv
// Single-outstanding initiator for the request/finish bus.
// Define BUS_MASTER_TIMEOUT_EN to abort transactions after TIMEOUT cycles without Finish.
module bus_master
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   bus_master_if.master bus,
   output state_t       o_state
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_cmd;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   logic              w_cmd_nxt;
   logic              w_rw_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [DATA_W-1:0] w_wdata_nxt;
   logic              w_rsp_valid_nxt;
   logic [DATA_W-1:0] w_rsp_rdata_nxt;
   logic              w_rsp_err_nxt;

   logic              w_accept;
   logic              w_timeout;

   assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

`ifdef BUS_MASTER_TIMEOUT_EN
   // Finish masks the enable, so a completion in the expiry cycle wins.
   bus_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_accept),
      .i_en      ((r_state == ST_BUSY) && !bus.Finish),
      .o_expired (w_timeout)
   );
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.req_valid)            w_state_nxt = ST_BUSY;
         ST_BUSY: if (bus.Finish || w_timeout)  w_state_nxt = ST_IDLE;
         default:                               w_state_nxt = ST_IDLE;
      endcase
   end

   // Cmd falls on the same edge that samples Finish so a responder never repeats it.
   always_comb begin
      w_cmd_nxt       = r_cmd;
      w_rw_nxt        = r_rw;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      case (r_state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               w_cmd_nxt   = 1'b1;
               w_rw_nxt    = bus.req_rw;
               w_addr_nxt  = bus.req_addr;
               w_wdata_nxt = bus.req_wdata;
            end
         end
         ST_BUSY: begin
            if (bus.Finish) begin
               w_cmd_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b0;
               w_rsp_rdata_nxt = r_rw ? '0 : bus.RData;
            end else if (w_timeout) begin
               w_cmd_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_rdata_nxt = '0;
            end
         end
         default: begin
            w_cmd_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd       <= 1'b0;
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_cmd       <= w_cmd_nxt;
         r_rw        <= w_rw_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign bus.req_ready = (r_state == ST_IDLE);
   assign bus.Cmd       = r_cmd;
   assign bus.RW        = r_rw;
   assign bus.Addr      = r_addr;
   assign bus.WData     = r_wdata;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign o_state       = r_state;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master with a 16-byte RAM responder that supports wait cycles.
`timescale 1ns/1ps
module tb_bus_master;
   import bus_pkg::*;

   localparam int unsigned TB_TIMEOUT = 8;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dut_state;

   bus_master_if bif();

   bus_master #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bif),
      .o_state (dut_state)
   );

   always #5 clk = ~clk;

   // RAM responder: answers addresses below 0x10 after wait_cycles extra cycles
   logic [7:0] mem [0:15];
   int         wait_cycles = 0;
   int         resp_cnt;
   logic       resp_fin;
   logic       stray_fin = 1'b0;
   logic [7:0] resp_rdata;

   assign bif.Finish = resp_fin | stray_fin;
   assign bif.RData  = resp_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_fin   <= 1'b0;
         resp_cnt   <= 0;
         resp_rdata <= 8'h00;
      end else begin
         resp_fin <= 1'b0;
         if (bif.Cmd && !resp_fin && (bif.Addr < 16'h0010)) begin
            if (resp_cnt < wait_cycles) begin
               resp_cnt <= resp_cnt + 1;
            end else begin
               resp_fin <= 1'b1;
               resp_cnt <= 0;
               if (bif.RW) mem[bif.Addr[3:0]] <= bif.WData;
               else        resp_rdata <= mem[bif.Addr[3:0]];
            end
         end
      end
   end

   int cmd_cycles = 0;
   int fin_count  = 0;
   always @(negedge clk) begin
      if (bif.Cmd === 1'b1)    cmd_cycles <= cmd_cycles + 1;
      if (bif.Finish === 1'b1) fin_count  <= fin_count + 1;
   end

   // scoreboard: {rsp_err, rsp_rdata}
   logic [8:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic do_txn(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                         input int budget, output int lat, output logic [7:0] rd, output logic er);
      @(negedge clk);
      bif.req_rw    = rw;
      bif.req_addr  = addr;
      bif.req_wdata = wd;
      bif.req_valid = 1'b1;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      lat = 0;
      while (bif.rsp_valid !== 1'b1 && lat < budget) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = bif.rsp_rdata;
      er = bif.rsp_err;
   endtask

   task automatic test_reset();
      logic [36:0] obs;
      repeat (2) @(negedge clk);
      obs = {bif.req_ready, bif.Cmd, bif.RW, bif.Addr, bif.WData, bif.rsp_valid, bif.rsp_rdata, bif.rsp_err};
      n_checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0})
         $display("FAIL reset_outputs: got %h expected %h", obs, {1'b1, 36'h0});
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_state !== ST_IDLE || bif.req_ready !== 1'b1)
         $display("FAIL reset_idle: got state %0d ready %b expected state 0 ready 1", dut_state, bif.req_ready);
      else n_pass++;
   endtask

   task automatic test_write_read();
      int lat, c0, f0;
      logic [7:0] rd;
      logic er;
      logic [8:0] exp;
      c0 = cmd_cycles; f0 = fin_count;
      exp_q.push_back({1'b0, 8'h00});
      do_txn(1'b1, 16'h0003, 8'h5A, 20, lat, rd, er);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else n_pass++;
      n_checks++;
      if ({er, rd} !== exp) $display("FAIL wr_rsp: got %h expected %h", {er, rd}, exp); else n_pass++;
      n_checks++;
      if (cmd_cycles - c0 !== 2) $display("FAIL wr_cmd_cycles: got %0d expected 2", cmd_cycles - c0); else n_pass++;
      n_checks++;
      if (fin_count - f0 !== 1) $display("FAIL wr_finish_count: got %0d expected 1", fin_count - f0); else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bif.rsp_valid !== 1'b0) $display("FAIL rsp_single_pulse: got %b expected 0", bif.rsp_valid); else n_pass++;

      c0 = cmd_cycles;
      exp_q.push_back({1'b0, 8'h5A});
      do_txn(1'b0, 16'h0003, 8'h00, 20, lat, rd, er);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 2) $display("FAIL rd_latency: got %0d expected 2", lat); else n_pass++;
      n_checks++;
      if ({er, rd} !== exp) $display("FAIL rd_rsp: got %h expected %h", {er, rd}, exp); else n_pass++;
      n_checks++;
      if (cmd_cycles - c0 !== 2) $display("FAIL rd_cmd_cycles: got %0d expected 2", cmd_cycles - c0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] wd [3];
      int acc [3];
      int idx, cyc, nrsp, f0;
      logic accepting;
      logic [8:0] exp;
      wd = '{8'h11, 8'h22, 8'h33};
      for (int ph = 0; ph < 2; ph++) begin
         idx = 0; cyc = 0; nrsp = 0; f0 = fin_count;
         acc = '{0, 0, 0};
         @(negedge clk);
         bif.req_rw    = (ph == 0);
         bif.req_addr  = 16'h0000;
         bif.req_wdata = wd[0];
         bif.req_valid = 1'b1;
         while ((idx < 3 || nrsp < 3) && cyc < 60) begin
            accepting = bif.req_valid && bif.req_ready;
            @(posedge clk); #1;
            cyc++;
            if (accepting) begin
               acc[idx] = cyc;
               exp_q.push_back((ph == 0) ? 9'h000 : {1'b0, wd[idx]});
               idx++;
               if (idx < 3) begin
                  bif.req_addr  = 16'(idx);
                  bif.req_wdata = wd[idx];
               end else begin
                  bif.req_valid = 1'b0;
               end
            end
            if (bif.rsp_valid === 1'b1) begin
               nrsp++;
               n_checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL b2b_rsp_unexpected: got rsp %h expected none", {bif.rsp_err, bif.rsp_rdata});
               end else begin
                  exp = exp_q.pop_front();
                  if ({bif.rsp_err, bif.rsp_rdata} !== exp)
                     $display("FAIL b2b_rsp ph%0d: got %h expected %h", ph, {bif.rsp_err, bif.rsp_rdata}, exp);
                  else n_pass++;
               end
            end
            @(negedge clk);
         end
         bif.req_valid = 1'b0;
         n_checks++;
         if (nrsp !== 3 || idx !== 3) $display("FAIL b2b_count ph%0d: got %0d/%0d expected 3/3", ph, idx, nrsp); else n_pass++;
         n_checks++;
         if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3)
            $display("FAIL b2b_spacing ph%0d: got %0d,%0d expected 3,3", ph, acc[1] - acc[0], acc[2] - acc[1]);
         else n_pass++;
         n_checks++;
         if (fin_count - f0 !== 3) $display("FAIL b2b_finish_count ph%0d: got %0d expected 3", ph, fin_count - f0); else n_pass++;
      end
   endtask

   task automatic test_wait_states();
      int lat;
      logic [7:0] rd;
      logic er;
      logic stable;
      logic [8:0] exp;
      exp_q.push_back({1'b0, 8'h00});
      do_txn(1'b1, 16'h000F, 8'hC3, 20, lat, rd, er);
      exp = exp_q.pop_front();
      @(negedge clk);
      wait_cycles = 5;
      exp_q.push_back({1'b0, 8'hC3});
      bif.req_rw    = 1'b0;
      bif.req_addr  = 16'h000F;
      bif.req_wdata = 8'h00;
      bif.req_valid = 1'b1;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      bif.req_addr  = 16'h0009;
      lat = 0; stable = 1'b1;
      while (bif.rsp_valid !== 1'b1 && lat < 30) begin
         if (bif.Cmd !== 1'b1 || bif.Addr !== 16'h000F || bif.RW !== 1'b0 || bif.req_ready !== 1'b0) stable = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 7) $display("FAIL wait_latency: got %0d expected 7", lat); else n_pass++;
      n_checks++;
      if (stable !== 1'b1) $display("FAIL wait_bus_stable: got %b expected 1", stable); else n_pass++;
      n_checks++;
      if ({bif.rsp_err, bif.rsp_rdata} !== exp)
         $display("FAIL wait_rsp: got %h expected %h", {bif.rsp_err, bif.rsp_rdata}, exp);
      else n_pass++;
      @(negedge clk);
      wait_cycles = 0;
   endtask

`ifdef BUS_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int lat, c0;
      logic [7:0] rd;
      logic er;
      logic [8:0] exp;
      c0 = cmd_cycles;
      exp_q.push_back({1'b1, 8'h00});
      do_txn(1'b0, 16'h8000, 8'h00, 40, lat, rd, er);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 8) $display("FAIL timeout_latency: got %0d expected 8", lat); else n_pass++;
      n_checks++;
      if ({er, rd} !== exp) $display("FAIL timeout_rsp: got %h expected %h", {er, rd}, exp); else n_pass++;
      n_checks++;
      if (cmd_cycles - c0 !== 8) $display("FAIL timeout_cmd_cycles: got %0d expected 8", cmd_cycles - c0); else n_pass++;
   endtask
`endif

   task automatic test_stray_finish();
      @(negedge clk);
      stray_fin = 1'b1;
      @(posedge clk); #1;
      stray_fin = 1'b0;
      n_checks++;
      if (bif.rsp_valid !== 1'b0 || bif.Cmd !== 1'b0 || dut_state !== ST_IDLE)
         $display("FAIL stray_finish: got valid %b cmd %b state %0d expected 0 0 0", bif.rsp_valid, bif.Cmd, dut_state);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bif.rsp_valid !== 1'b0) $display("FAIL stray_finish_late: got %b expected 0", bif.rsp_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [7:0] rd;
      logic er;
      logic quiet;
      logic [8:0] exp;
      @(negedge clk);
      wait_cycles = 20;
      bif.req_rw    = 1'b0;
      bif.req_addr  = 16'h0005;
      bif.req_valid = 1'b1;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (bif.Cmd !== 1'b1) $display("FAIL mid_busy: got cmd %b expected 1", bif.Cmd); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bif.Cmd !== 1'b0 || bif.req_ready !== 1'b1 || bif.rsp_valid !== 1'b0)
         $display("FAIL mid_reset_async: got cmd %b ready %b valid %b expected 0 1 0", bif.Cmd, bif.req_ready, bif.rsp_valid);
      else n_pass++;
      quiet = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bif.rsp_valid !== 1'b0 || bif.Cmd !== 1'b0) quiet = 1'b0;
      end
      exp_q.delete();
      wait_cycles = 0;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bif.rsp_valid !== 1'b0) quiet = 1'b0;
      end
      n_checks++;
      if (quiet !== 1'b1) $display("FAIL mid_reset_no_rsp: got %b expected 1", quiet); else n_pass++;

      exp_q.push_back({1'b0, 8'h00});
      do_txn(1'b1, 16'h0001, 8'h77, 20, lat, rd, er);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 2 || {er, rd} !== exp)
         $display("FAIL post_reset_wr: got lat %0d rsp %h expected lat 2 rsp %h", lat, {er, rd}, exp);
      else n_pass++;
      exp_q.push_back({1'b0, 8'h77});
      do_txn(1'b0, 16'h0001, 8'h00, 20, lat, rd, er);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 2 || {er, rd} !== exp)
         $display("FAIL post_reset_rd: got lat %0d rsp %h expected lat 2 rsp %h", lat, {er, rd}, exp);
      else n_pass++;
   endtask

   initial begin
      bif.req_valid = 1'b0;
      bif.req_rw    = 1'b0;
      bif.req_addr  = 16'h0000;
      bif.req_wdata = 8'h00;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_wait_states();
`ifdef BUS_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_stray_finish();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_master.md
# bus_master

Initiator for the on-chip request/finish bus. It accepts single read/write requests from a client such as the UART command decoder or a DMA sequencer. It drives `Cmd`/`Addr`/`RW`/`WData` toward the bus responders, waits for the responder's one-cycle `Finish` pulse, and returns read data plus a status pulse to the client. An optional watchdog terminates transactions addressed to unmapped space.

## Interface
- `TIMEOUT`, default 255: maximum cycles `Cmd` is held without `Finish` before the transaction is aborted (1..65535). Used only with the watchdog macro.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  master can accept a request.
- `req_rw`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  target address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; valid while `rsp_valid` is high.
- `rsp_err`  out  1  1 = transaction timed out; valid while `rsp_valid` is high.
- `Cmd`  out  1  bus command strobe.
- `RW`  out  1  bus direction, 1 = write.
- `Addr`  out  16  bus address.
- `WData`  out  8  bus write data.
- `RData`  in  8  bus read data; valid in the cycle `Finish` is high.
- `Finish`  in  1  responder completion, one-cycle pulse.

## Operation
- FSM has two states: IDLE and BUSY.
- Reset values: state IDLE, `req_ready`=1, `Cmd`=0, `RW`=0, `Addr`=0, `WData`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, watchdog count 0.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register `req_rw`/`req_addr`/`req_wdata` onto `RW`/`Addr`/`WData`, set `Cmd`<=1, clear the watchdog and go to BUSY.
- BUSY:
  - `req_ready`=0.
  - `Cmd`, `Addr`, `RW` and `WData` are held stable.
  - On `Finish`=1: `Cmd`<=0, `rsp_valid`<=1, `rsp_err`<=0, go to IDLE.
  - `rsp_rdata`<=`RData` for a read and 0 for a write.
- `rsp_valid` is a single-cycle pulse. It clears on the next edge unless another completion occurs.
- `Finish` is ignored in IDLE. This covers stray and late pulses.
- `Cmd` must drop on the same edge that samples `Finish`. Responders return to their wait state one cycle after `Finish` and would otherwise execute the command twice.
- Back-to-back operation: a new request may be accepted in the cycle `rsp_valid` is high.

## Timing
- Request accepted at edge A; `Cmd` is high from A.
- A zero-wait responder samples at A+1 and raises `Finish` after A+1.
- The master samples `Finish` at A+2 and drives `rsp_valid` high after A+2. Minimum latency is 2 cycles from acceptance to response.
- Minimum issue rate is 1 transaction per 3 cycles: accept, BUSY, and IDLE with response.
- Latency grows by one cycle per responder wait cycle, with no upper bound unless the watchdog is enabled.
- Reset asserted mid-transaction drops `Cmd` and `rsp_valid` immediately (asynchronously) and discards the transaction. No response is generated.

## Configuration
- Macro: `BUS_MASTER_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter increments each BUSY cycle without `Finish`.
  - When it reaches `TIMEOUT`: `Cmd`<=0, `rsp_valid`<=1, `rsp_err`<=1, `rsp_rdata`<=0, go to IDLE.
  - If `Finish` and the timeout occur in the same cycle, `Finish` wins (`rsp_err`=0).
- Not defined: no counter; BUSY waits indefinitely; `rsp_err` is tied to 0; `TIMEOUT` is unused.

## Structure
- Shared package `bus_pkg`: state encoding (IDLE, BUSY), bus address width 16, data width 8, default `TIMEOUT` constant.
- One sub-module, `bus_watchdog`: a counter with clear, enable and `expired` output, instantiated only under `BUS_MASTER_TIMEOUT_EN`.

## Test plan
- Write 0x5A to 0x0003, then read 0x0003, both against the 16-byte RAM responder. Required: `rsp_valid` 2 cycles after each accept, `rsp_err`=0, read returns 0x5A, `Cmd` high exactly 2 cycles per transaction.
- Back-to-back writes of 0x11, 0x22 and 0x33 to 0x0000..0x0002 with `req_valid` held high, then three reads. Required: accepts 3 cycles apart, reads return 0x11, 0x22, 0x33, and each transaction produces exactly one `Finish`.
- Responder injects 5 wait cycles on a read of 0x000F. Required: `Cmd`/`Addr` stable throughout, `req_ready`=0, response at 7 cycles.
- With the macro defined and `TIMEOUT`=8, read 0x8000 (no responder). Required: `Cmd` drops after 8 cycles, `rsp_err`=1, `rsp_rdata`=0. A later stray `Finish` in IDLE produces no `rsp_valid`.
- Assert `rst_n`=0 while BUSY. Required: `Cmd`=0 and `req_ready`=1 immediately with no response pulse; a post-reset write/read of 0x0001 succeeds.
